// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-ported memory.
// Define MEM_PORT_ARBITER_TIMEOUT_EN to bound the memory wait and flag err.
module mem_port_arbiter #(
  parameter int WIDTH          = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic             i_ack,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_ack,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             sel,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef struct packed {
    logic             sel;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
  } xfer_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  state_t           state_q, state_d;
  xfer_t            xfer_q, xfer_d;
  logic [SW-1:0]    streak_q, streak_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             pick_d;
  logic             timeout;

  // Data has priority until fetch has been passed over STARVE_LIMIT times.
  assign pick_d = d_req && !(i_req && streak_q == SLIM);

  always_comb begin
    state_d  = state_q;
    xfer_d   = xfer_q;
    streak_d = streak_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          xfer_d.sel   = pick_d;
          xfer_d.we    = pick_d & d_we;
          xfer_d.addr  = pick_d ? d_addr : i_addr;
          xfer_d.wdata = pick_d ? d_wdata : '0;
          if (pick_d && i_req)
            streak_d = (streak_q == SLIM) ? SLIM
                                          : streak_q + 1'b1;
          else
            streak_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          rdata_d = xfer_q.we ? '0 : mem_rdata;
          state_d = DONE;
        end else if (timeout) begin
          rdata_d = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      xfer_q   <= '0;
      streak_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      xfer_q   <= xfer_d;
      streak_q <= streak_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt_q;
  logic          err_q;

  assign timeout = (state_q == BUSY) && !mem_ready
                && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= timeout;
      if (state_q == BUSY && !mem_ready)
        tcnt_q <= tcnt_q + 1'b1;
      else
        tcnt_q <= '0;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign mem_req   = (state_q == BUSY);
  assign i_ack     = (state_q == DONE) && !xfer_q.sel;
  assign d_ack     = (state_q == DONE) && xfer_q.sel;
  assign sel       = xfer_q.sel;
  assign mem_we    = xfer_q.we;
  assign mem_addr  = xfer_q.addr;
  assign mem_wdata = xfer_q.wdata;
  assign rdata     = rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, data/address width; STARVE_LIMIT, 4, consecutive data grants tolerated while fetch waits; TIMEOUT_CYCLES, 16, memory wait limit.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_req  input  1  instruction-fetch request, held high until i_ack.
REQ-005 i_addr  input  WIDTH  fetch address.
REQ-006 i_ack  output  1  one-cycle fetch completion pulse.
REQ-007 d_req  input  1  data request, held high until d_ack.
REQ-008 d_we  input  1  data write enable (1=store, 0=load).
REQ-009 d_addr  input  WIDTH  data address.
REQ-010 d_wdata  input  WIDTH  store data.
REQ-011 d_ack  output  1  one-cycle data completion pulse.
REQ-012 rdata  output  WIDTH  registered read data, valid in the ack cycle.
REQ-013 mem_req  output  1  memory access strobe.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  WIDTH  registered memory address.
REQ-016 mem_wdata  output  WIDTH  registered memory write data.
REQ-017 mem_rdata  input  WIDTH  memory read data, valid when mem_ready=1.
REQ-018 mem_ready  input  1  memory completion, sampled only while mem_req=1.
REQ-019 sel  output  1  address-mux select for current owner (0=fetch, 1=data).
REQ-020 err  output  1  timeout flag, pulses with the ack (timeout build only).

Function
REQ-021 FSM SHALL have states IDLE, BUSY, DONE.
REQ-022 IDLE: no request -> stay IDLE; any request -> arbitrate, capture winner's addr/we/wdata into mem_addr/mem_we/mem_wdata, set sel, go BUSY.
REQ-023 Arbitration: only one requester -> it wins; both -> data wins unless streak==STARVE_LIMIT, then fetch wins.
REQ-024 Streak counter SHALL increment on a data grant while i_req=1, saturating at STARVE_LIMIT; it SHALL clear on a fetch grant or on a data grant with i_req=0.
REQ-025 Fetch grants SHALL force mem_we=0 and mem_wdata=0.
REQ-026 BUSY: mem_req=1; on mem_ready=1 capture mem_rdata into rdata (0 for stores), go DONE; else stay BUSY.
REQ-027 DONE: mem_req=0, assert exactly one of i_ack/d_ack per sel for one cycle, ignore all requests, go IDLE.
REQ-028 Latency: request seen in IDLE at cycle 0 -> mem_req high from cycle 1; mem_ready at cycle k -> ack at cycle k+1; minimum transaction 3 cycles.
REQ-029 mem_addr, mem_we, mem_wdata and sel SHALL hold stable from BUSY entry through DONE.
REQ-030 Requester input changes during BUSY/DONE SHALL have no effect on the current transaction.
REQ-031 i_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE and clear streak counter, timeout counter, and all outputs (mem_req, mem_we, mem_addr, mem_wdata, rdata, sel, i_ack, d_ack, err) to 0.
REQ-033 Reset during BUSY SHALL abandon the transaction with no ack; after release, pending requests SHALL be arbitrated from IDLE.

Configuration
REQ-034 Macro MEM_PORT_ARBITER_TIMEOUT_EN defined: BUSY SHALL count cycles without mem_ready; on the TIMEOUT_CYCLES-th such cycle go DONE with rdata=0, err=1 and the owner's ack in the DONE cycle.
REQ-035 Macro not defined: BUSY SHALL wait indefinitely and err SHALL be tied 0.

Verification
REQ-036 d_req=1, d_we=0, d_addr=0x40, mem_ready at cycle 2 with mem_rdata=0xDEADBEEF -> mem_req cycles 1-2, sel=1, d_ack and rdata=0xDEADBEEF at cycle 3.
REQ-037 i_req and d_req held high continuously, mem_ready=1 always -> grant sequence D,D,D,D,I,D,D,D,D,I...; at most one ack per cycle.
REQ-038 d_req store, d_wdata=0x12345678, d_addr=0x80 -> mem_we=1, mem_wdata=0x12345678, mem_addr=0x80 held through BUSY; d_ack with rdata=0.
REQ-039 rst_n low during BUSY -> mem_req=0 immediately, no ack; after release, held d_req regranted from cycle 1.
REQ-040 Timeout build, mem_ready held 0 after i_req -> i_ack and err=1 together one cycle after the 16th BUSY cycle, rdata=0; non-timeout build -> mem_req stays high.
